// File: rtl/emaxi_read_master.sv
// AXI4 read-initiator bridge: one outstanding read, narrow-lane extraction, 2-entry response buffer.
// Optional macro EMAXI_RID_CHECK_EN adds R-ID checking and the sticky err_rid output.
`timescale 1ns/1ps
module emaxi_read_master #(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic           clk,
  input  logic           m_axi_aresetn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [AW-1:0]  req_addr,
  input  logic [IDW-1:0] req_id,
  input  logic [7:0]     req_len,
  input  logic [2:0]     req_size,
  input  logic [1:0]     req_burst,
  output logic           m_axi_arvalid,
  input  logic           m_axi_arready,
  output logic [AW-1:0]  m_axi_araddr,
  output logic [IDW-1:0] m_axi_arid,
  output logic [7:0]     m_axi_arlen,
  output logic [2:0]     m_axi_arsize,
  output logic [1:0]     m_axi_arburst,
  output logic [3:0]     m_axi_arcache,
  output logic [2:0]     m_axi_arprot,
  output logic           m_axi_arlock,
  output logic [3:0]     m_axi_arqos,
  input  logic           m_axi_rvalid,
  output logic           m_axi_rready,
  input  logic [DW-1:0]  m_axi_rdata,
  input  logic [IDW-1:0] m_axi_rid,
  input  logic [1:0]     m_axi_rresp,
  input  logic           m_axi_rlast,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_data,
  output logic [1:0]     rsp_resp,
  output logic           rsp_last,
  output logic [IDW-1:0] rsp_id,
  output logic           err_len
`ifdef EMAXI_RID_CHECK_EN
  ,
  output logic           err_rid
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  trk_addr;
  logic [2:0]     trk_size;
  logic [1:0]     trk_burst;
  logic [7:0]     beat_cnt;

  logic [1:0]     fifo_cnt;
  logic           wr_ptr, rd_ptr;
  logic [DW-1:0]  buf_data [2];
  logic [1:0]     buf_resp [2];
  logic           buf_last [2];
  logic [IDW-1:0] buf_id   [2];

  logic           accept, ar_hs, r_hs, beat_end, len_bad, push, pop;
  logic [DW-1:0]  beat_data;
  logic [1:0]     beat_resp;
  logic           beat_last;

  function automatic logic [DW-1:0] lane_extract(input logic [DW-1:0] d,
                                                 input logic [1:0]    lane,
                                                 input logic [2:0]    size);
    logic [DW-1:0] r;
    r = d;
    case (size)
      3'd0:    r = {{(DW-8){1'b0}}, d[{lane, 3'b000} +: 8]};
      3'd1:    r = {{(DW-16){1'b0}}, d[{lane[1], 4'b0000} +: 16]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Align down to the transfer size, then step one beat; wraps at AW bits.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic [2:0]    size);
    logic [AW-1:0] step;
    step = AW'(1) << size;
    return (a & ~(step - AW'(1))) + step;
  endfunction

  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arqos   = 4'b0000;

  assign accept       = req_valid && (state == S_IDLE);
  assign ar_hs        = m_axi_arvalid && m_axi_arready;
  assign m_axi_rready = (state == S_DATA) && (fifo_cnt != 2'd2);
  assign r_hs         = m_axi_rvalid && m_axi_rready;
  assign beat_end     = (beat_cnt == 8'd0) || m_axi_rlast;
  assign len_bad      = (m_axi_rlast && (beat_cnt != 8'd0)) ||
                        (!m_axi_rlast && (beat_cnt == 8'd0));
  assign beat_last    = beat_end;
  assign beat_data    = lane_extract(m_axi_rdata, trk_addr[1:0], trk_size);

`ifdef EMAXI_RID_CHECK_EN
  logic rid_bad;
  assign rid_bad   = (m_axi_rid != m_axi_arid);
  assign beat_resp = rid_bad ? 2'b10 : m_axi_rresp;
`else
  assign beat_resp = m_axi_rresp;
`endif

  always_ff @(posedge clk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_ADDR;
      end
      S_ADDR:  if (m_axi_arready) state_nxt = S_DATA;
      S_DATA:  if (r_hs && beat_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command capture, AR channel and per-beat address tracking
  always_ff @(posedge clk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arid    <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      trk_addr      <= '0;
      trk_size      <= '0;
      trk_burst     <= '0;
      beat_cnt      <= '0;
      err_len       <= 1'b0;
    end else begin
      if (accept) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= req_addr;
        m_axi_arid    <= req_id;
        m_axi_arlen   <= req_len;
        m_axi_arsize  <= req_size;
        m_axi_arburst <= req_burst;
        trk_addr      <= req_addr;
        trk_size      <= req_size;
        trk_burst     <= req_burst;
        beat_cnt      <= req_len;
      end else if (ar_hs) begin
        m_axi_arvalid <= 1'b0;
      end
      if (r_hs && !beat_end) begin
        beat_cnt <= beat_cnt - 8'd1;
        if (trk_burst == 2'b01) trk_addr <= next_addr(trk_addr, trk_size);
      end
      if (r_hs && len_bad) err_len <= 1'b1;
    end
  end

`ifdef EMAXI_RID_CHECK_EN
  always_ff @(posedge clk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn)       err_rid <= 1'b0;
    else if (r_hs && rid_bad) err_rid <= 1'b1;
  end
`endif

  // Response buffer: rready depends only on registered occupancy
  assign push = r_hs;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      fifo_cnt    <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_resp[0] <= '0;
      buf_resp[1] <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
      buf_id[0]   <= '0;
      buf_id[1]   <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= beat_data;
        buf_resp[wr_ptr] <= beat_resp;
        buf_last[wr_ptr] <= beat_last;
        buf_id[wr_ptr]   <= m_axi_rid;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign rsp_valid = (fifo_cnt != 2'd0);
  assign rsp_data  = buf_data[rd_ptr];
  assign rsp_resp  = buf_resp[rd_ptr];
  assign rsp_last  = buf_last[rd_ptr];
  assign rsp_id    = buf_id[rd_ptr];

endmodule

// File: tb/tb_emaxi_read_master.sv
// Directed self-checking bench for emaxi_read_master; ID-check scenario built with EMAXI_RID_CHECK_EN.
`timescale 1ns/1ps
module tb_emaxi_read_master;
  localparam int IDW = 12;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready;
  logic [AW-1:0]  req_addr;
  logic [IDW-1:0] req_id;
  logic [7:0]     req_len;
  logic [2:0]     req_size;
  logic [1:0]     req_burst;
  logic           m_axi_arvalid, m_axi_arready;
  logic [AW-1:0]  m_axi_araddr;
  logic [IDW-1:0] m_axi_arid;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic [3:0]     m_axi_arcache;
  logic [2:0]     m_axi_arprot;
  logic           m_axi_arlock;
  logic [3:0]     m_axi_arqos;
  logic           m_axi_rvalid, m_axi_rready;
  logic [DW-1:0]  m_axi_rdata;
  logic [IDW-1:0] m_axi_rid;
  logic [1:0]     m_axi_rresp;
  logic           m_axi_rlast;
  logic           rsp_valid, rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic [1:0]     rsp_resp;
  logic           rsp_last;
  logic [IDW-1:0] rsp_id;
  logic           err_len;
`ifdef EMAXI_RID_CHECK_EN
  logic           err_rid;
`endif

  emaxi_read_master #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .m_axi_aresetn(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_id(req_id),
    .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arlock(m_axi_arlock), .m_axi_arqos(m_axi_arqos),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_last(rsp_last), .rsp_id(rsp_id), .err_len(err_len)
`ifdef EMAXI_RID_CHECK_EN
    , .err_rid(err_rid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [1:0]     r;
    logic           l;
    logic [IDW-1:0] id;
  } rsp_t;

  rsp_t           q[$];
  int             n_vec = 0;
  int             n_bad = 0;
  logic [31:0]    bd [8];
  logic           bl [8];
  logic [IDW-1:0] b_rid;
  logic [1:0]     b_resp;

  always @(posedge clk)
    if (rst_n && rsp_valid && rsp_ready) q.push_back({rsp_data, rsp_resp, rsp_last, rsp_id});

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0; rsp_ready = 1'b1; b_resp = 2'b00;
    tick; tick;
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic issue(input logic [31:0] addr, input logic [IDW-1:0] id, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input int ar_dly);
    req_valid = 1'b1; req_addr = addr; req_id = id; req_len = len; req_size = size; req_burst = burst;
    b_rid = id;
    n_vec++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL req_ready_idle got=%b want=1", req_ready); end
    tick;
    req_valid = 1'b0;
    n_vec++;
    if (m_axi_arvalid !== 1'b1) begin n_bad++; $display("FAIL arvalid_rise got=%b want=1", m_axi_arvalid); end
    n_vec++;
    if ({m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {addr, id, len, size, burst}) begin
      n_bad++;
      $display("FAIL ar_fields got=%h/%h/%h/%h/%h want=%h/%h/%h/%h/%h", m_axi_araddr, m_axi_arid,
               m_axi_arlen, m_axi_arsize, m_axi_arburst, addr, id, len, size, burst);
    end
    repeat (ar_dly) tick;
    m_axi_arready = 1'b1;
    tick;
    m_axi_arready = 1'b0;
    n_vec++;
    if (m_axi_arvalid !== 1'b0) begin n_bad++; $display("FAIL arvalid_drop got=%b want=0", m_axi_arvalid); end
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      m_axi_rvalid = 1'b1; m_axi_rdata = bd[i]; m_axi_rlast = bl[i];
      m_axi_rid = b_rid; m_axi_rresp = b_resp;
      g = 0;
      while (m_axi_rready !== 1'b1 && g < 200) begin tick; g++; end
      if (g >= 200) begin n_vec++; n_bad++; $display("FAIL r_handshake_timeout beat=%0d", i); end
      tick;
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int g;
    g = 0;
    while (q.size() < n && g < 200) begin tick; g++; end
    repeat (2) tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b1;
    m_axi_rlast = 1'b1; rsp_ready = 1'b1;
    tick;
    n_vec++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    n_vec++;
    if ({m_axi_arvalid, m_axi_rready, rsp_valid, err_len} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_ctrl got=%b want=0000", {m_axi_arvalid, m_axi_rready, rsp_valid, err_len});
    end
    n_vec++;
    if ({m_axi_arcache, m_axi_arprot, m_axi_arlock, m_axi_arqos} !== 12'b0011_000_0_0000) begin
      n_bad++; $display("FAIL rst_sideband got=%b want=001100000000",
                        {m_axi_arcache, m_axi_arprot, m_axi_arlock, m_axi_arqos});
    end
    n_vec++;
    if ({m_axi_araddr, rsp_data, rsp_last} !== 65'd0) begin
      n_bad++; $display("FAIL rst_data got=%h/%h/%b want=0", m_axi_araddr, rsp_data, rsp_last);
    end
    do_reset;
  endtask

  task automatic test_single;
    do_reset;
    bd[0] = 32'hDEADBEEF; bl[0] = 1'b1;
    issue(32'h0000_1000, 12'h003, 8'd0, 3'd2, 2'b01, 2);
    send_beats(1);
    n_vec++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL single_req_ready got=%b want=1", req_ready); end
    n_vec++;
    if ({rsp_valid, rsp_data, rsp_last} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin
      n_bad++; $display("FAIL single_latency got=%b/%h/%b want=1/deadbeef/1", rsp_valid, rsp_data, rsp_last);
    end
    wait_rsp(1);
    n_vec++;
    if (q.size() !== 1 || q[0].d !== 32'hDEADBEEF || q[0].l !== 1'b1 || q[0].id !== 12'h003) begin
      n_bad++; $display("FAIL single_rsp got=n%0d/%h/%b want=n1/deadbeef/1", q.size(), q[0].d, q[0].l);
    end
  endtask

  task automatic test_incr_byte;
    logic [31:0] exp_d [4];
    exp_d = '{32'h22, 32'h33, 32'h44, 32'h11};
    do_reset;
    for (int i = 0; i < 4; i++) begin bd[i] = 32'h44332211; bl[i] = (i == 3); end
    issue(32'h0000_2001, 12'h011, 8'd3, 3'd0, 2'b01, 0);
    send_beats(4);
    wait_rsp(4);
    n_vec++;
    if (q.size() !== 4) begin n_bad++; $display("FAIL incr_byte_count got=%0d want=4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (q[i].d !== exp_d[i] || q[i].l !== (i == 3)) begin
        n_bad++; $display("FAIL incr_byte_beat%0d got=%h/%b want=%h/%b", i, q[i].d, q[i].l, exp_d[i], (i == 3));
      end
    end
  endtask

  task automatic test_wrap;
    do_reset;
    bd[0] = 32'h44332211; bl[0] = 1'b0; bd[1] = 32'h44332211; bl[1] = 1'b1;
    issue(32'hFFFF_FFFF, 12'h012, 8'd1, 3'd0, 2'b01, 0);
    send_beats(2);
    wait_rsp(2);
    n_vec++;
    if (q.size() !== 2 || q[0].d !== 32'h44 || q[1].d !== 32'h11) begin
      n_bad++; $display("FAIL addr_wrap got=n%0d/%h/%h want=n2/44/11", q.size(), q[0].d, q[1].d);
    end
  endtask

  task automatic test_fixed_half;
    do_reset;
    bd[0] = 32'hAAAA5555; bl[0] = 1'b0; bd[1] = 32'hAAAA5555; bl[1] = 1'b1;
    issue(32'h0000_3002, 12'h021, 8'd1, 3'd1, 2'b00, 1);
    send_beats(2);
    wait_rsp(2);
    n_vec++;
    if (q.size() !== 2 || q[0].d !== 32'h0000AAAA || q[1].d !== 32'h0000AAAA || q[1].l !== 1'b1) begin
      n_bad++; $display("FAIL fixed_half got=n%0d/%h/%h/%b want=n2/0000aaaa/0000aaaa/1",
                        q.size(), q[0].d, q[1].d, q[1].l);
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin bd[i] = 32'hA0 + i; bl[i] = (i == 3); end
    issue(32'h0000_4000, 12'h002, 8'd3, 3'd2, 2'b01, 1);
    fork
      send_beats(4);
      begin
        repeat (6) tick;
        n_vec++;
        if (m_axi_rready !== 1'b0 || rsp_valid !== 1'b1) begin
          n_bad++; $display("FAIL bp_stall got=rready%b/valid%b want=rready0/valid1", m_axi_rready, rsp_valid);
        end
        n_vec++;
        if (q.size() !== 0) begin n_bad++; $display("FAIL bp_no_pop got=%0d want=0", q.size()); end
        rsp_ready = 1'b1;
      end
    join
    wait_rsp(4);
    n_vec++;
    if (q.size() !== 4) begin n_bad++; $display("FAIL bp_count got=%0d want=4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (q[i].d !== 32'hA0 + i || q[i].l !== (i == 3)) begin
        n_bad++; $display("FAIL bp_beat%0d got=%h/%b want=%h/%b", i, q[i].d, q[i].l, 32'hA0 + i, (i == 3));
      end
    end
  endtask

  task automatic test_len_mismatch;
    do_reset;
    bd[0] = 32'h1; bl[0] = 1'b0; bd[1] = 32'h2; bl[1] = 1'b1;
    issue(32'h0000_7000, 12'h031, 8'd2, 3'd2, 2'b01, 0);
    send_beats(2);
    n_vec++;
    if ({err_len, req_ready, m_axi_rready} !== 3'b110) begin
      n_bad++; $display("FAIL early_last got=err%b/rdy%b/rready%b want=1/1/0", err_len, req_ready, m_axi_rready);
    end
    wait_rsp(2);
    n_vec++;
    if (q.size() !== 2 || q[1].l !== 1'b1 || q[1].d !== 32'h2) begin
      n_bad++; $display("FAIL early_last_rsp got=n%0d/%b/%h want=n2/1/2", q.size(), q[1].l, q[1].d);
    end
    do_reset;
    n_vec++;
    if (err_len !== 1'b0) begin n_bad++; $display("FAIL err_len_clear got=%b want=0", err_len); end
    bd[0] = 32'h5; bl[0] = 1'b0;
    issue(32'h0000_7100, 12'h032, 8'd0, 3'd2, 2'b01, 0);
    send_beats(1);
    n_vec++;
    if ({err_len, req_ready} !== 2'b11) begin
      n_bad++; $display("FAIL missing_last got=err%b/rdy%b want=1/1", err_len, req_ready);
    end
    wait_rsp(1);
    n_vec++;
    if (q.size() !== 1 || q[0].l !== 1'b1) begin
      n_bad++; $display("FAIL missing_last_rsp got=n%0d/%b want=n1/1", q.size(), q[0].l);
    end
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    rsp_ready = 1'b0;
    bd[0] = 32'h11111111; bl[0] = 1'b0;
    issue(32'h0000_5000, 12'h007, 8'd3, 3'd2, 2'b01, 0);
    send_beats(1);
    n_vec++;
    if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre got=%b want=1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rsp_valid, req_ready, m_axi_rready, m_axi_arvalid} !== 4'b0100 || m_axi_araddr !== 32'h0 ||
        rsp_data !== 32'h0) begin
      n_bad++; $display("FAIL mid_async got=v%b/r%b/rr%b/av%b/%h/%h want=0/1/0/0/0/0", rsp_valid, req_ready,
                        m_axi_rready, m_axi_arvalid, m_axi_araddr, rsp_data);
    end
    #2 rst_n = 1'b1;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hBAD0BAD0; m_axi_rlast = 1'b0; rsp_ready = 1'b1;
    repeat (3) tick;
    n_vec++;
    if ({rsp_valid, m_axi_rready} !== 2'b00 || q.size() !== 0) begin
      n_bad++; $display("FAIL mid_no_beat got=v%b/rr%b/n%0d want=0/0/n0", rsp_valid, m_axi_rready, q.size());
    end
    m_axi_rvalid = 1'b0;
    bd[0] = 32'hCAFEF00D; bl[0] = 1'b0; bd[1] = 32'h12345678; bl[1] = 1'b1;
    issue(32'h0000_6000, 12'h008, 8'd1, 3'd2, 2'b01, 0);
    send_beats(2);
    wait_rsp(2);
    n_vec++;
    if (q.size() !== 2 || q[0].d !== 32'hCAFEF00D || q[1].d !== 32'h12345678 || q[1].l !== 1'b1) begin
      n_bad++; $display("FAIL mid_recover got=n%0d/%h/%h/%b want=n2/cafef00d/12345678/1",
                        q.size(), q[0].d, q[1].d, q[1].l);
    end
  endtask

`ifdef EMAXI_RID_CHECK_EN
  task automatic test_rid;
    do_reset;
    bd[0] = 32'h0BADF00D; bl[0] = 1'b1;
    issue(32'h0000_8000, 12'h003, 8'd0, 3'd2, 2'b01, 0);
    b_rid = 12'h005; b_resp = 2'b00;
    send_beats(1);
    n_vec++;
    if (err_rid !== 1'b1) begin n_bad++; $display("FAIL rid_flag got=%b want=1", err_rid); end
    wait_rsp(1);
    n_vec++;
    if (q.size() !== 1 || q[0].r !== 2'b10 || q[0].id !== 12'h005) begin
      n_bad++; $display("FAIL rid_resp got=n%0d/%b/%h want=n1/10/005", q.size(), q[0].r, q[0].id);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_id = '0; req_len = '0; req_size = '0;
    req_burst = '0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rid = '0;
    m_axi_rresp = '0; m_axi_rlast = 1'b0; rsp_ready = 1'b1; b_rid = '0; b_resp = '0;
    test_reset;
    test_single;
    test_incr_byte;
    test_wrap;
    test_fixed_half;
    test_backpressure;
    test_len_mismatch;
    test_reset_mid_burst;
`ifdef EMAXI_RID_CHECK_EN
    test_rid;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
